// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and parity polarity.
// The PARITY state exists only when UART_RX_PARITY_EN is defined.
package uart_pkg;

  localparam int DATA_BITS = 8;

  // Required XOR over data bits plus parity bit (even parity).
  localparam logic PARITY_EVEN = 1'b0;

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK
  } uart_state_t;
`else
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BREAK
  } uart_state_t;
`endif

  function automatic logic parity_bad(input logic [DATA_BITS-1:0] data, input logic par);
    return (^{data, par}) != PARITY_EVEN;
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receiver output bundle; master = receiver, slave = byte consumer.
// o_Rx_Parity_Err exists only when UART_RX_PARITY_EN is defined.
interface uart_rx_if;
  logic       o_Rx_DV;
  logic [7:0] o_Rx_Byte;
  logic       o_Rx_Frame_Err;
  logic       o_Rx_Active;
`ifdef UART_RX_PARITY_EN
  logic       o_Rx_Parity_Err;

  modport master (output o_Rx_DV, o_Rx_Byte, o_Rx_Frame_Err, o_Rx_Active, o_Rx_Parity_Err);
  modport slave  (input  o_Rx_DV, o_Rx_Byte, o_Rx_Frame_Err, o_Rx_Active, o_Rx_Parity_Err);
`else
  modport master (output o_Rx_DV, o_Rx_Byte, o_Rx_Frame_Err, o_Rx_Active);
  modport slave  (input  o_Rx_DV, o_Rx_Byte, o_Rx_Frame_Err, o_Rx_Active);
`endif
endinterface

// File: rtl/uart_sync.sv
// Two-flop synchroniser for an asynchronous single-bit input.
// Latency: 2 cycles. No backpressure; level signal only.
module uart_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic i_Clock,
  input  logic i_Rst_L,
  input  logic line,
  output logic line_s
);

  logic meta;

  always_ff @(posedge i_Clock) begin
    if (!i_Rst_L) begin
      meta   <= RST_VAL;
      line_s <= RST_VAL;
    end else begin
      meta   <= line;
      line_s <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver (8E1 with UART_RX_PARITY_EN): mid-bit sampling, errored frames flagged.
// Latency: byte valid 3 + HALF + (frame_bits-1)*CLKS_PER_BIT + 1 edges after the line falls.
// No backpressure: o_Rx_Byte holds until the next good frame, consumer must keep up.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 2
) (
  input  logic     i_Clock,
  input  logic     i_Rst_L,
  input  logic     i_Rx_Serial,
  uart_rx_if.master rx
);

  localparam logic [7:0] HALF = 8'((CLKS_PER_BIT - 1) / 2);
  localparam logic [7:0] LAST = 8'(CLKS_PER_BIT - 1);

  uart_state_t           state;
  logic [7:0]            clk_cnt;
  logic [2:0]            bit_idx;
  logic [DATA_BITS-1:0]  shift;
  logic                  rx_s;
`ifdef UART_RX_PARITY_EN
  logic                  par_bad;
`endif

  uart_sync #(.RST_VAL(1'b1)) u_sync (
    .i_Clock (i_Clock),
    .i_Rst_L (i_Rst_L),
    .line    (i_Rx_Serial),
    .line_s  (rx_s)
  );

  always_ff @(posedge i_Clock) begin
    if (!i_Rst_L) begin
      state             <= ST_IDLE;
      clk_cnt           <= 8'd0;
      bit_idx           <= 3'd0;
      shift             <= '0;
      rx.o_Rx_DV        <= 1'b0;
      rx.o_Rx_Byte      <= 8'h00;
      rx.o_Rx_Frame_Err <= 1'b0;
      rx.o_Rx_Active    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      rx.o_Rx_Parity_Err <= 1'b0;
      par_bad            <= 1'b0;
`endif
    end else begin
      rx.o_Rx_DV        <= 1'b0;
      rx.o_Rx_Frame_Err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      rx.o_Rx_Parity_Err <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          clk_cnt <= 8'd0;
          bit_idx <= 3'd0;
          if (!rx_s) state <= ST_START;
        end

        // A start bit that is high again at mid-period was a glitch.
        ST_START: begin
          if (clk_cnt == HALF) begin
            clk_cnt <= 8'd0;
            if (!rx_s) begin
              state          <= ST_DATA;
              rx.o_Rx_Active <= 1'b1;
            end else begin
              state <= ST_IDLE;
            end
          end else begin
            clk_cnt <= clk_cnt + 8'd1;
          end
        end

        ST_DATA: begin
          if (clk_cnt == LAST) begin
            clk_cnt        <= 8'd0;
            shift[bit_idx] <= rx_s;
            if (bit_idx == 3'd7) begin
              bit_idx <= 3'd0;
`ifdef UART_RX_PARITY_EN
              state   <= ST_PARITY;
`else
              state   <= ST_STOP;
`endif
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            clk_cnt <= clk_cnt + 8'd1;
          end
        end

`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (clk_cnt == LAST) begin
            clk_cnt <= 8'd0;
            par_bad <= parity_bad(shift, rx_s);
            state   <= ST_STOP;
          end else begin
            clk_cnt <= clk_cnt + 8'd1;
          end
        end
`endif

        ST_STOP: begin
          if (clk_cnt == LAST) begin
            clk_cnt        <= 8'd0;
            rx.o_Rx_Active <= 1'b0;
`ifdef UART_RX_PARITY_EN
            // Parity error wins; the stop bit only decides whether to wait out a break.
            if (par_bad) begin
              rx.o_Rx_Parity_Err <= 1'b1;
              state              <= rx_s ? ST_IDLE : ST_BREAK;
            end else
`endif
            if (rx_s) begin
              rx.o_Rx_Byte <= shift;
              rx.o_Rx_DV   <= 1'b1;
              state        <= ST_IDLE;
            end else begin
              rx.o_Rx_Frame_Err <= 1'b1;
              state             <= ST_BREAK;
            end
          end else begin
            clk_cnt <= clk_cnt + 8'd1;
          end
        end

        // A held-low line must return high before a new start bit is accepted.
        ST_BREAK: begin
          clk_cnt <= 8'd0;
          if (rx_s) state <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed frames plus random back-to-back traffic.
module tb_uart_rx;

  localparam int CPB  = 4;
  localparam int HALF = (CPB - 1) / 2;
`ifdef UART_RX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  // Edges from the line falling (just after edge E0) to the DV edge.
  localparam int DV_LAT  = 3 + HALF + (NB - 1) * CPB + 1;
  localparam int ACT_LEN = (NB - 1) * CPB;

  logic i_Clock     = 1'b0;
  logic i_Rst_L     = 1'b0;
  logic i_Rx_Serial = 1'b1;

  uart_rx_if rx ();

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .i_Clock     (i_Clock),
    .i_Rst_L     (i_Rst_L),
    .i_Rx_Serial (i_Rx_Serial),
    .rx          (rx)
  );

  always #5 i_Clock = ~i_Clock;

  int cyc = 0;
  always @(posedge i_Clock) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
    end
  endtask

  // Observation side: everything is sampled on the falling edge.
  logic [7:0] dv_q[$];
  int         dv_cyc_q[$];
  int         ferr_n = 0;
  int         perr_n = 0;
  int         act_n  = 0;

  always @(negedge i_Clock) begin
    if (rx.o_Rx_DV) begin
      dv_q.push_back(rx.o_Rx_Byte);
      dv_cyc_q.push_back(cyc);
    end
    if (rx.o_Rx_Frame_Err) ferr_n++;
`ifdef UART_RX_PARITY_EN
    if (rx.o_Rx_Parity_Err) perr_n++;
`endif
    if (rx.o_Rx_Active) act_n++;
  end

  // Frame as a bit list, transmitted index 0 first.
  function automatic logic [10:0] build(input logic [7:0] d, input logic stop, input logic par_ok);
    logic [10:0] f;
    f      = '1;
    f[0]   = 1'b0;
    f[8:1] = d;
`ifdef UART_RX_PARITY_EN
    f[9]   = (^d) ^ ~par_ok;
    f[10]  = stop;
`else
    f[9]   = stop;
`endif
    return f;
  endfunction

  // Called #1 after an edge; that edge is E0 of the frame.
  task automatic send(input logic [7:0] d, input logic stop, input logic par_ok, output int e0);
    logic [10:0] f;
    f  = build(d, stop, par_ok);
    e0 = cyc;
    for (int i = 0; i < NB; i++) begin
      i_Rx_Serial = f[i];
      repeat (CPB) @(posedge i_Clock);
      #1;
    end
  endtask

  task automatic idle(input int n);
    i_Rx_Serial = 1'b1;
    repeat (n) @(posedge i_Clock);
    #1;
  endtask

  int         e0, base, fbase, pbase, abase;
  logic [7:0] exp_q[$];
  logic [7:0] b;

  initial begin
    repeat (3) @(posedge i_Clock);
    #1;
    chk("rst_dv",     int'(rx.o_Rx_DV),        0);
    chk("rst_byte",   int'(rx.o_Rx_Byte),      0);
    chk("rst_ferr",   int'(rx.o_Rx_Frame_Err), 0);
    chk("rst_active", int'(rx.o_Rx_Active),    0);
`ifdef UART_RX_PARITY_EN
    chk("rst_perr",   int'(rx.o_Rx_Parity_Err), 0);
`endif
    i_Rst_L = 1'b1;

    idle(50);
    chk("idle_dv",     dv_q.size(), 0);
    chk("idle_ferr",   ferr_n,      0);
    chk("idle_active", act_n,       0);
    chk("idle_byte",   int'(rx.o_Rx_Byte), 0);

    // Single frame: latency and active window.
    base = dv_q.size(); abase = act_n;
    send(8'hA5, 1'b1, 1'b1, e0);
    idle(8);
    chk("a5_count",  dv_q.size() - base, 1);
    if (dv_q.size() > base) begin
      chk("a5_byte", int'(dv_q[base]), 8'hA5);
      chk("a5_lat",  dv_cyc_q[base] - e0, DV_LAT);
    end
    chk("a5_active", act_n - abase, ACT_LEN);
    chk("a5_hold",   int'(rx.o_Rx_Byte), 8'hA5);

    // Back-to-back, no idle gap.
    base = dv_q.size();
    send(8'h00, 1'b1, 1'b1, e0);
    send(8'hFF, 1'b1, 1'b1, e0);
    send(8'h3C, 1'b1, 1'b1, e0);
    idle(10);
    chk("b2b_count", dv_q.size() - base, 3);
    if (dv_q.size() >= base + 3) begin
      chk("b2b_0", int'(dv_q[base]),     8'h00);
      chk("b2b_1", int'(dv_q[base + 1]), 8'hFF);
      chk("b2b_2", int'(dv_q[base + 2]), 8'h3C);
    end

    // One-cycle glitch.
    base = dv_q.size(); fbase = ferr_n; abase = act_n;
    i_Rx_Serial = 1'b0;
    @(posedge i_Clock);
    #1;
    idle(30);
    chk("glitch_dv",     dv_q.size() - base, 0);
    chk("glitch_ferr",   ferr_n - fbase,     0);
    chk("glitch_active", act_n - abase,      0);

    // Bad stop bit then a long break.
    base = dv_q.size(); fbase = ferr_n; abase = act_n;
    send(8'h55, 1'b0, 1'b1, e0);
    repeat (100) @(posedge i_Clock);
    #1;
    chk("brk_ferr",   ferr_n - fbase,     1);
    chk("brk_dv",     dv_q.size() - base, 0);
    chk("brk_byte",   int'(rx.o_Rx_Byte), 8'h3C);
    chk("brk_active", act_n - abase,      ACT_LEN);
    idle(10);
    send(8'h81, 1'b1, 1'b1, e0);
    idle(8);
    chk("brk_next_count", dv_q.size() - base, 1);
    chk("brk_next_byte",  int'(rx.o_Rx_Byte), 8'h81);

    // Reset mid-data, held until the aborted frame has left the line.
    base = dv_q.size(); fbase = ferr_n; pbase = perr_n;
    fork
      send(8'hF0, 1'b1, 1'b1, e0);
      begin
        repeat (26) @(posedge i_Clock);
        #1;
        i_Rst_L = 1'b0;
        repeat (NB * CPB - 26) @(posedge i_Clock);
        #1;
        i_Rst_L = 1'b1;
      end
    join
    idle(10);
    chk("abort_dv",   dv_q.size() - base, 0);
    chk("abort_ferr", ferr_n - fbase,     0);
    chk("abort_perr", perr_n - pbase,     0);
    chk("abort_byte", int'(rx.o_Rx_Byte), 8'h00);
    send(8'h0F, 1'b1, 1'b1, e0);
    idle(8);
    chk("abort_next_count", dv_q.size() - base, 1);
    chk("abort_next_byte",  int'(rx.o_Rx_Byte), 8'h0F);

`ifdef UART_RX_PARITY_EN
    base = dv_q.size(); fbase = ferr_n; pbase = perr_n;
    send(8'h07, 1'b1, 1'b0, e0);
    idle(8);
    chk("par_perr", perr_n - pbase,     1);
    chk("par_dv",   dv_q.size() - base, 0);
    chk("par_ferr", ferr_n - fbase,     0);
    chk("par_byte", int'(rx.o_Rx_Byte), 8'h0F);
`endif

    // Random bytes with random 0..2 cycle gaps against a byte-order model.
    base = dv_q.size(); fbase = ferr_n;
    for (int n = 0; n < 24; n++) begin
      b = 8'($urandom_range(0, 255));
      exp_q.push_back(b);
      send(b, 1'b1, 1'b1, e0);
      idle($urandom_range(0, 2));
    end
    idle(20);
    chk("rnd_count", dv_q.size() - base, exp_q.size());
    chk("rnd_ferr",  ferr_n - fbase,     0);
    for (int n = 0; n < exp_q.size() && base + n < dv_q.size(); n++)
      chk($sformatf("rnd_byte%0d", n), int'(dv_q[base + n]), int'(exp_q[n]));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
